mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single-port 16x4 synchronous memory (memoria) between two requesters.
//   Grants at most one access per cycle and alternates round-robin when both request.
//   Returns read data with a tagged, fixed-latency response.
//   After reset it first clears the whole memory to zero, then opens both request ports.
// PARAMETERS
//   ADDR_W          4   memory address width; depth = 2**ADDR_W
//   DATA_W          4   memory data width
//   RD_LAT          1   memory read latency in cycles (1 or 2); sets response pipeline depth
//   CLEAR_ON_RESET  1   1: run INIT clear sweep after reset; 0: go straight to RUN
// PORTS
//   clk          in   1       single clock; everything is on the rising edge
//   rst_n        in   1       asynchronous, active-low reset
//   req0_valid   in   1       requester 0 has a command
//   req0_we      in   1       1 = write, 0 = read
//   req0_addr    in   ADDR_W  access address
//   req0_wdata   in   DATA_W  write data
//   req0_ready   out  1       command accepted this cycle (valid & ready)
//   rsp0_valid   out  1       read data for requester 0 valid this cycle
//   rsp0_rdata   out  DATA_W  read data
//   req1_*/rsp1_* (same set as port 0)   requester 1
//   mem_wea      out  1       memory write enable
//   mem_addra    out  ADDR_W  memory address
//   mem_dina     out  DATA_W  memory write data
//   mem_douta    in   DATA_W  memory read data, valid RD_LAT cycles after its address is sampled
//   init_done    out  1       high once the clear sweep finishes
// BEHAVIOUR
//   - Reset values: FSM=INIT (RUN if CLEAR_ON_RESET=0), init_done=0, all req*_ready=0, all rsp*_valid=0.
//     Reset also sets rsp*_rdata=0, rr_last=1 (port 0 wins the first tie), clear counter=0.
//     The response pipeline is flushed.
//   - FSM INIT: drive mem_wea=1, mem_addra=cnt, mem_dina=0 and increment cnt each cycle.
//     When cnt=2**ADDR_W-1 has been written, go to RUN and set init_done=1; total 2**ADDR_W cycles.
//     Both ready outputs stay 0 during INIT.
//   - FSM RUN: grant logic is combinational from valid and rr_last.
//     Only one valid -> that port wins. Both valid -> the port that is not rr_last wins.
//     rr_last updates to the winner only on a granted cycle.
//   - req_ready is asserted for the granted port only. The losing port's command must be held stable.
//   - mem_addra, mem_wea and mem_dina are combinational from the granted command.
//     With no grant they are held at 0 (mem_wea=0).
//   - Writes: no response. A read granted in cycle T is pushed into the RD_LAT-deep tag pipe
//     as {valid, port}. In cycle T+RD_LAT, rsp<port>_valid=1 and rsp<port>_rdata=mem_douta.
//   - Throughput: one access per cycle; back-to-back reads from either port are never stalled.
//   - Read after write to the same address in consecutive cycles returns the new data.
//   - Responses come back in grant order; each port sees its own reads in issue order.
//   - rsp*_rdata holds its last value while rsp*_valid=0.
//   - Reset in mid-operation (INIT or RUN): all state returns asynchronously to reset values.
//     In-flight reads are dropped (no rsp_valid). The INIT sweep restarts from address 0.
//   - Address width is fixed, so there is no wrap beyond depth. The INIT counter is ADDR_W+1 bits
//     so it can detect the end of the sweep.
// STRUCTURE
//   - Shared package mem_pkg: ADDR_W/DATA_W defaults, FSM state enum {INIT, RUN}, port-id
//     constants P0=0/P1=1, and rsp tag struct {valid, port}.
//   - One sub-module, rr_arb2: a 2-way round-robin grant with a registered rr_last
//     (inputs: valid[1:0], advance; output: grant[1:0]).
//   - The top level holds the FSM, clear counter, memory mux and RD_LAT-deep tag shift register.
//   - memoria is instantiated one level above, not inside this block.
// TESTING
//   - Reset then idle: init_done goes high exactly 16 cycles after rst_n rises, with mem_wea=1
//     for addresses 0..15 and dina=0. A read of every address then returns 4'h0.
//   - Port 0 writes addr 3 <- 4'hA. In the next cycle it reads addr 3.
//     Expect rsp0_valid one cycle after the read grant with rdata=4'hA, and rsp1_valid=0.
//   - Both ports hold reads valid for 6 cycles (p0 addr 1, p1 addr 2).
//     Expect grants P0,P1,P0,P1,P0,P1; responses alternate with the correct data and never collide.
//   - Port 1 only, 8 back-to-back reads of addr 0..7 preloaded with 8-x.
//     Expect req1_ready=1 every cycle and 8 consecutive rsp1_valid cycles with data 8..1.
//   - Assert rst_n=0 for one cycle while a read is in flight and at cnt=7 of INIT.
//     Expect no rsp_valid from the dropped read and the sweep to restart at addr 0.
//   - RD_LAT=2 build: repeat the alternating-read test. Responses arrive 2 cycles after grant,
//     in the same order.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths,
// FSM states, requester ids and the read-response tag.
package mem_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } rsp_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The registered rr_last remembers the most
// recent winner so the other port wins the next tie.
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic rr_last_q;
    logic rr_last_d;

    always_comb begin
        grant     = 2'b00;
        rr_last_d = rr_last_q;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (rr_last_q == P1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (advance && (grant != 2'b00)) begin
            rr_last_d = grant[1];
        end
    end

    // Resetting to P1 lets port 0 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= P1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between two requesters with
// round-robin grant, a post-reset clear sweep and tagged read responses.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    input  logic [DATA_W-1:0] mem_douta,
    output logic              init_done
);

    typedef logic [ADDR_W:0] cnt_t;

    localparam int     DEPTH       = 2 ** ADDR_W;
    localparam cnt_t   CNT_LAST    = cnt_t'(DEPTH - 1);
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? INIT : RUN;

    state_t                      state_q, state_d;
    cnt_t                        cnt_q, cnt_d;
    logic                        init_done_q, init_done_d;
    logic [DATA_W-1:0]           rdata0_q, rdata0_d;
    logic [DATA_W-1:0]           rdata1_q, rdata1_d;
    rsp_tag_t [RD_LAT-1:0]       tag_q, tag_d;
    rsp_tag_t                    out_tag;
    logic                        run;
    logic [1:0]                  grant;

    assign run = (state_q == RUN);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   ({req1_valid, req0_valid} & {2{run}}),
        .advance (run),
        .grant   (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign init_done  = init_done_q;

    // Clear sweep during INIT; afterwards the memory port follows the grant.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        mem_wea     = 1'b0;
        mem_addra   = '0;
        mem_dina    = '0;
        case (state_q)
            INIT: begin
                mem_wea   = 1'b1;
                mem_addra = cnt_q[ADDR_W-1:0];
                cnt_d     = cnt_t'(cnt_q + 1'b1);
                if (cnt_q == CNT_LAST) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                init_done_d = 1'b1;
                if (grant[0]) begin
                    mem_wea   = req0_we;
                    mem_addra = req0_addr;
                    mem_dina  = req0_wdata;
                end else if (grant[1]) begin
                    mem_wea   = req1_we;
                    mem_addra = req1_addr;
                    mem_dina  = req1_wdata;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // Each granted read enters the tag pipe; it pops out when mem_douta is valid.
    always_comb begin
        tag_d          = tag_q;
        tag_d[0].valid = (grant != 2'b00) && !mem_wea;
        tag_d[0].port  = grant[1];
        for (int k = 1; k < RD_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    assign out_tag    = tag_q[RD_LAT-1];
    assign rsp0_valid = out_tag.valid && (out_tag.port == P0);
    assign rsp1_valid = out_tag.valid && (out_tag.port == P1);
    assign rsp0_rdata = rsp0_valid ? mem_douta : rdata0_q;
    assign rsp1_rdata = rsp1_valid ? mem_douta : rdata1_q;
    assign rdata0_d   = rsp0_rdata;
    assign rdata1_d   = rsp1_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            tag_q       <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            tag_q       <= tag_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter with a behavioural memory
// model standing in for memoria.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int RD_LAT = 1;

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [3:0] data;
    } cmd_t;

    typedef struct {
        logic       port;
        logic [3:0] data;
        int         cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req0_valid = 1'b0, req0_we = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic [DATA_W-1:0] req0_wdata = '0;
    logic              req1_valid = 1'b0, req1_we = 1'b0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic [DATA_W-1:0] req1_wdata = '0;
    logic              req0_ready, rsp0_valid, req1_ready, rsp1_valid;
    logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
    logic              mem_wea;
    logic [ADDR_W-1:0] mem_addra;
    logic [DATA_W-1:0] mem_dina, mem_douta;
    logic              init_done;

    logic [3:0] ram [16];
    logic [3:0] rdPipe [RD_LAT];
    logic       garbageEn = 1'b1;
    int         cyc = 0;

    logic [3:0] modelMem [16];
    logic       lastWin;
    logic [3:0] lastRd0, lastRd1;
    cmd_t       q0[$], q1[$];
    exp_t       expQ[$];
    int         checks = 0;
    int         errors = 0;

    mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
        .mem_douta(mem_douta), .init_done(init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: pre-filled with non-zero garbage so the clear sweep matters.
    always @(posedge clk) begin
        rdPipe[0] <= ram[mem_addra];
        for (int k = 1; k < RD_LAT; k++) rdPipe[k] <= rdPipe[k-1];
        if (garbageEn) begin
            for (int k = 0; k < 16; k++) ram[k] <= 4'(k) | 4'h8;
        end else if (mem_wea) begin
            ram[mem_addra] <= mem_dina;
        end
    end
    assign mem_douta = rdPipe[RD_LAT-1];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic resetModel();
        for (int k = 0; k < 16; k++) modelMem[k] = 4'h0;
        lastWin = P1;
        lastRd0 = 4'h0;
        lastRd1 = 4'h0;
        expQ.delete();
        q0.delete();
        q1.delete();
    endtask

    // Walks the clear sweep one cycle at a time; abortAt pulses reset mid-sweep.
    task automatic checkInit(input int abortAt);
        for (int i = 0; i < 16; i++) begin
            req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'($urandom);
            req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 4'($urandom);
            #2;
            checkOutput("init_step", 32'({init_done, req1_ready, req0_ready, mem_wea, mem_addra, mem_dina}),
                        32'({1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 4'h0}));
            if (i == abortAt) begin
                rst_n = 1'b0;
                resetModel();
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #2;
        checkOutput("init_done", 32'({init_done, mem_wea}), 32'(2'b10));
        @(negedge clk);
    endtask

    task automatic doReset();
        #2;
        rst_n = 1'b0;
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        checkInit(16);
    endtask

    // Presents queued commands, predicts the round-robin winner and scoreboards reads.
    task automatic applyStimulus(input int gapPct, input int budget);
        int   c = 0;
        logic held0 = 1'b0, held1 = 1'b0;
        logic v0, v1, w, any;
        cmd_t cmd;
        while ((q0.size() > 0 || q1.size() > 0 || expQ.size() > 0) && c < budget) begin
            v0 = (q0.size() > 0) && (held0 || $urandom_range(99) >= gapPct);
            v1 = (q1.size() > 0) && (held1 || $urandom_range(99) >= gapPct);
            req0_valid = v0;
            req1_valid = v1;
            if (v0) begin req0_we = q0[0].we; req0_addr = q0[0].addr; req0_wdata = q0[0].data; end
            else    begin req0_we = 1'($urandom); req0_addr = 4'($urandom); req0_wdata = 4'($urandom); end
            if (v1) begin req1_we = q1[0].we; req1_addr = q1[0].addr; req1_wdata = q1[0].data; end
            else    begin req1_we = 1'($urandom); req1_addr = 4'($urandom); req1_wdata = 4'($urandom); end
            #2;
            any = v0 || v1;
            w   = (v0 && v1) ? ~lastWin : v1;
            checkOutput("grant", 32'({req1_ready, req0_ready}),
                        32'(any ? (w ? 2'b10 : 2'b01) : 2'b00));
            if (any) begin
                cmd = w ? q1.pop_front() : q0.pop_front();
                if (cmd.we) modelMem[cmd.addr] = cmd.data;
                else        expQ.push_back('{port: w, data: modelMem[cmd.addr], cyc: cyc});
                lastWin = w;
            end
            held0 = v0 && !(any && w == P0);
            held1 = v1 && !(any && w == P1);
            @(negedge clk);
            c++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (c >= budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0 pending", expQ.size() + q0.size() + q1.size());
            expQ.delete();
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic monitorLoop();
        logic       p;
        logic [3:0] d;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rsp0_valid && rsp1_valid) begin
                checkOutput("rsp_collision", 32'({rsp1_valid, rsp0_valid}), 32'(2'b00));
            end else if (rsp0_valid || rsp1_valid) begin
                p = rsp1_valid;
                d = p ? rsp1_rdata : rsp0_rdata;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_rsp", 32'({rsp1_valid, rsp0_valid}), 32'(2'b00));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rsp_port_data_lat", {11'd0, p, d, 16'(cyc)},
                                {11'd0, e.port, e.data, 16'(e.cyc + RD_LAT)});
                    if (p) lastRd1 = e.data;
                    else   lastRd0 = e.data;
                end
            end else begin
                checkOutput("rdata_hold", 32'({rsp1_rdata, rsp0_rdata}), 32'({lastRd1, lastRd0}));
            end
        end
    endtask

    task automatic pushReadAll();
        for (int a = 0; a < 16; a++) begin
            if (a % 2 == 0) q0.push_back('{we: 1'b0, addr: 4'(a), data: 4'h0});
            else            q1.push_back('{we: 1'b0, addr: 4'(a), data: 4'h0});
        end
    endtask

    initial begin
        resetModel();
        fork
            monitorLoop();
        join_none
        @(negedge clk);
        @(negedge clk);
        garbageEn = 1'b0;
        rst_n = 1'b1;
        checkInit(16);

        // After the sweep every location reads back as zero.
        pushReadAll();
        applyStimulus(0, 200);

        // Write then immediately read the same address from port 0.
        q0.push_back('{we: 1'b1, addr: 4'd3, data: 4'hA});
        q0.push_back('{we: 1'b0, addr: 4'd3, data: 4'h0});
        applyStimulus(0, 50);

        // Tied reads alternate, port 0 first after reset.
        doReset();
        q1.push_back('{we: 1'b1, addr: 4'd1, data: 4'h5});
        q1.push_back('{we: 1'b1, addr: 4'd2, data: 4'h9});
        applyStimulus(0, 50);
        for (int i = 0; i < 6; i++) begin
            q0.push_back('{we: 1'b0, addr: 4'd1, data: 4'h0});
            q1.push_back('{we: 1'b0, addr: 4'd2, data: 4'h0});
        end
        applyStimulus(0, 100);

        // Port 1 streams eight reads of addresses preloaded with 8-x.
        for (int x = 0; x < 8; x++) q0.push_back('{we: 1'b1, addr: 4'(x), data: 4'(8 - x)});
        applyStimulus(0, 100);
        for (int x = 0; x < 8; x++) q1.push_back('{we: 1'b0, addr: 4'(x), data: 4'h0});
        applyStimulus(0, 100);

        for (int i = 0; i < 300; i++) begin
            q0.push_back('{we: 1'($urandom), addr: 4'($urandom), data: 4'($urandom)});
            q1.push_back('{we: 1'($urandom), addr: 4'($urandom), data: 4'($urandom)});
        end
        applyStimulus(30, 3000);

        // Reset while a read is in flight: its response must never appear.
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'd5;
        #2;
        checkOutput("inflight_grant", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        resetModel();
        @(negedge clk);
        checkOutput("dropped_rsp", 32'({rsp1_valid, rsp0_valid}), 32'(2'b00));
        rst_n = 1'b1;
        checkInit(7);
        checkInit(16);

        pushReadAll();
        applyStimulus(0, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
